// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: register map, status/control bit
// positions, FSM state encoding and a counter-width helper.
package spi_master_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOP     = 3'd6;

    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 4;
    localparam int ST_TMT  = 5;
    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;
    localparam int ST_E    = 8;
    localparam int ST_EOP  = 9;

    localparam int CT_IROE  = 3;
    localparam int CT_ITOE  = 4;
    localparam int CT_ITRDY = 6;
    localparam int CT_IRRDY = 7;
    localparam int CT_IE    = 8;
    localparam int CT_IEOP  = 9;
    localparam int CT_SSO   = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // Bits needed to hold n-1; never less than one so tiny counts still get a register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Avalon-MM register-access bundle between the CPU fabric (master) and the
// SPI master core (slave).
interface spi_master_if;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;
    logic        irq;

    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu, irq
    );

    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu, irq
    );
endinterface

// File: rtl/spi_master_tick.sv
// SCLK half-period timer: down-counter that fires a one-cycle tick every
// CLK_DIV clocks and reloads on tick or while restart is held.
module spi_master_tick
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 196
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int             CW     = clog2(CLK_DIV);
    localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RELOAD;
        end else if (restart || count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0) && !restart;

endmodule

// File: rtl/spi_master_core.sv
// Avalon-MM controlled SPI master (mode 0, MSB first, single SS_n).
// Optional end-of-packet register/status enabled by SPI_MASTER_EOP_EN.
//
// state | meaning
// IDLE  | SS_n high, waiting for a word in tx_holding
// SETUP | SS_n low, MSB on MOSI, one half-period before first SCLK rise
// SHIFT | SCLK toggling; rise samples MISO, fall shifts and drives next bit
// HOLD  | SCLK low for one half-period, then publish the received word
// GAP   | SS_n high for GAP_CYCLES clocks before the next word may start
module spi_master_core
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 196,
    parameter int GAP_CYCLES = 196
) (
    input  logic         clk,
    input  logic         reset_n,
    spi_master_if.slave  bus,
    output logic         SCLK,
    output logic         MOSI,
    input  logic         MISO,
    output logic         SS_n
);

    localparam int                BW       = clog2(DATA_WIDTH);
    localparam logic [BW-1:0]     BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam int                GW       = clog2(GAP_CYCLES);
    localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYCLES - 1);

    localparam logic [31:0] CTRL_BASE = (32'd1 << CT_IROE) | (32'd1 << CT_ITOE) |
                                        (32'd1 << CT_ITRDY) | (32'd1 << CT_IRRDY) |
                                        (32'd1 << CT_IE) | (32'd1 << CT_SSO);
`ifdef SPI_MASTER_EOP_EN
    localparam logic [31:0] CTRL_MASK = CTRL_BASE | (32'd1 << CT_IEOP);
`else
    localparam logic [31:0] CTRL_MASK = CTRL_BASE & ~(32'd1 << CT_IEOP);
`endif

    state_t                  state;
    logic                    sclk, mosi, ss_n;
    logic [DATA_WIDTH-1:0]   shift_reg, tx_holding, rx_holding;
    logic                    rx_bit;
    logic [BW-1:0]           bit_cnt;
    logic [GW-1:0]           gap_cnt;
    logic                    trdy, rrdy, roe, toe;
    logic                    tick, tick_restart;

    logic                    strobe_d1, rx_rd_d1, irq_q;
    logic                    access, wr_en, rd_en;
    logic                    wr_tx, wr_status, wr_control, rd_rx;
    logic [31:0]             ctrl_reg, data_to_cpu_q, read_mux, status_word, rx_word;
    logic [31:0]             eop_value;
    logic                    eop;

    // Each access is held for two cycles; only the first one acts.
    assign access     = bus.spi_select & (~bus.read_n | ~bus.write_n) & ~strobe_d1;
    assign wr_en      = access & ~bus.write_n;
    assign rd_en      = access & ~bus.read_n;
    assign wr_tx      = wr_en && bus.mem_addr == ADDR_TXDATA;
    assign wr_status  = wr_en && bus.mem_addr == ADDR_STATUS;
    assign wr_control = wr_en && bus.mem_addr == ADDR_CONTROL;
    assign rd_rx      = rd_en && bus.mem_addr == ADDR_RXDATA;

    assign rx_word = 32'(rx_holding);

    always_comb begin
        status_word          = '0;
        status_word[ST_ROE]  = roe;
        status_word[ST_TOE]  = toe;
        status_word[ST_TMT]  = trdy && state == S_IDLE;
        status_word[ST_TRDY] = trdy;
        status_word[ST_RRDY] = rrdy;
        status_word[ST_E]    = roe | toe;
        status_word[ST_EOP]  = eop;
    end

    always_comb begin
        read_mux = '0;
        case (bus.mem_addr)
            ADDR_RXDATA:  read_mux = rx_word;
            ADDR_STATUS:  read_mux = status_word;
            ADDR_CONTROL: read_mux = ctrl_reg;
            ADDR_EOP:     read_mux = eop_value;
            default:      read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_d1     <= 1'b0;
            rx_rd_d1      <= 1'b0;
            ctrl_reg      <= '0;
            data_to_cpu_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            strobe_d1 <= access;
            rx_rd_d1  <= rd_rx;
            if (wr_control) ctrl_reg <= bus.data_from_cpu & CTRL_MASK;
            if (rd_en) data_to_cpu_q <= read_mux;
            irq_q <= |(status_word & ctrl_reg);
        end
    end

`ifdef SPI_MASTER_EOP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eop_value <= '0;
            eop       <= 1'b0;
        end else begin
            if (wr_en && bus.mem_addr == ADDR_EOP) eop_value <= bus.data_from_cpu;
            if (wr_status) eop <= 1'b0;
            if ((wr_tx && bus.data_from_cpu == eop_value) || (rd_rx && rx_word == eop_value))
                eop <= 1'b1;
        end
    end
`else
    assign eop_value = '0;
    assign eop       = 1'b0;
`endif

    // Every other state entry coincides with a tick, which reloads the timer anyway.
    assign tick_restart = (state == S_IDLE) || (state == S_GAP);

    spi_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (tick_restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            ss_n       <= 1'b1;
            shift_reg  <= '0;
            rx_bit     <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            trdy       <= 1'b1;
            rrdy       <= 1'b0;
            roe        <= 1'b0;
            toe        <= 1'b0;
            tx_holding <= '0;
            rx_holding <= '0;
        end else begin
            if (wr_tx) begin
                if (trdy) begin
                    tx_holding <= bus.data_from_cpu[DATA_WIDTH-1:0];
                    trdy       <= 1'b0;
                end else begin
                    toe <= 1'b1;
                end
            end
            if (wr_status) begin
                roe  <= 1'b0;
                toe  <= 1'b0;
                rrdy <= 1'b0;
            end
            if (rx_rd_d1) rrdy <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!trdy) begin
                        shift_reg <= tx_holding;
                        mosi      <= tx_holding[DATA_WIDTH-1];
                        trdy      <= 1'b1;
                        ss_n      <= 1'b0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        sclk    <= 1'b1;
                        rx_bit  <= MISO;
                        bit_cnt <= BIT_LAST;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        if (!sclk) begin
                            sclk   <= 1'b1;
                            rx_bit <= MISO;
                        end else begin
                            sclk      <= 1'b0;
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], rx_bit};
                            if (bit_cnt == '0) begin
                                mosi  <= 1'b0;
                                state <= S_HOLD;
                            end else begin
                                mosi    <= shift_reg[DATA_WIDTH-2];
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        // A read clearing RRDY this cycle frees the holding register.
                        if (!rrdy || rx_rd_d1) begin
                            rx_holding <= shift_reg;
                            rrdy       <= 1'b1;
                        end else begin
                            roe  <= 1'b1;
                            rrdy <= 1'b1;
                        end
                        if (ctrl_reg[CT_SSO] && !trdy) begin
                            shift_reg <= tx_holding;
                            mosi      <= tx_holding[DATA_WIDTH-1];
                            trdy      <= 1'b1;
                            state     <= S_SETUP;
                        end else begin
                            ss_n    <= 1'b1;
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) state <= S_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign SCLK            = sclk;
    assign MOSI            = mosi;
    assign SS_n            = ss_n;
    assign bus.data_to_cpu = data_to_cpu_q;
    assign bus.irq         = irq_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core with a fast SCLK (CLK_DIV=4, GAP_CYCLES=8)
// and MISO looped back from MOSI (optionally inverted).
module tb_spi_master_core;

    localparam logic [2:0] A_RX   = 3'd0;
    localparam logic [2:0] A_TX   = 3'd1;
    localparam logic [2:0] A_ST   = 3'd2;
    localparam logic [2:0] A_CTRL = 3'd3;
    localparam logic [2:0] A_EOP  = 3'd6;

    logic clk;
    logic reset_n;
    logic sclk, mosi, miso, ss_n;
    logic miso_inv;

    int          n_cmp = 0;
    int          n_err = 0;
    int          rise_cnt = 0;
    int          ss_rise_cnt = 0;
    logic [31:0] mosi_cap = '0;
    time         t_prev = 0, t_last = 0, t_up = 0, gap_ns = 0;

    spi_master_if bus();

    spi_master_core #(.DATA_WIDTH(32), .CLK_DIV(4), .GAP_CYCLES(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .SCLK    (sclk),
        .MOSI    (mosi),
        .MISO    (miso),
        .SS_n    (ss_n)
    );

    assign miso = mosi ^ miso_inv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge sclk) begin
        if (!ss_n) begin
            mosi_cap <= {mosi_cap[30:0], mosi};
            rise_cnt <= rise_cnt + 1;
            t_prev   <= t_last;
            t_last   <= $time;
        end
    end

    always @(posedge ss_n) begin
        t_up        <= $time;
        ss_rise_cnt <= ss_rise_cnt + 1;
    end

    always @(negedge ss_n) gap_ns <= $time - t_up;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        cyc(1);
        bus.spi_select = 1'b1; bus.mem_addr = a; bus.write_n = 1'b0; bus.data_from_cpu = d;
        cyc(2);
        bus.spi_select = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        cyc(1);
        bus.spi_select = 1'b1; bus.mem_addr = a; bus.read_n = 1'b0;
        cyc(2);
        d = bus.data_to_cpu;
        bus.spi_select = 1'b0; bus.read_n = 1'b1;
    endtask

    task automatic wait_ss(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (ss_n !== lvl && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, 32'(ss_n), 32'(lvl));
    endtask

    task automatic wait_sclk_high(input int budget, input string tag);
        int n;
        n = 0;
        while (sclk !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, 32'(sclk), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int rb, sb;

        bus.spi_select = 1'b0; bus.mem_addr = '0; bus.read_n = 1'b1;
        bus.write_n = 1'b1; bus.data_from_cpu = '0;
        miso_inv = 1'b0;
        reset_n  = 1'b0;
        cyc(3);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ss_n", 32'(ss_n), 32'd1);
        check("rst_dout", bus.data_to_cpu, 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        reset_n = 1'b1;
        cyc(1);
        bus_read(A_ST, rd);   check("rst_status", rd, 32'h60);
        bus_read(A_CTRL, rd); check("rst_control", rd, 32'h0);
        bus_read(A_RX, rd);   check("rst_rxdata", rd, 32'h0);
        bus_write(A_ST, 32'h0);

        // single loopback word
        rb = rise_cnt;
        bus_write(A_TX, 32'hA5A5_0F0F);
        wait_ss(1'b0, 20, "t1_ss_low");
        wait_ss(1'b1, 400, "t1_ss_high");
        check("t1_rises", 32'(rise_cnt - rb), 32'd32);
        check("t1_mosi", mosi_cap, 32'hA5A5_0F0F);
        check("t1_sclk_period", 32'(t_last - t_prev), 32'd80);
        cyc(12);
        bus_read(A_ST, rd); check("t1_status", rd, 32'hE0);
        bus_read(A_RX, rd); check("t1_rxdata", rd, 32'hA5A5_0F0F);
        bus_read(A_ST, rd); check("t1_status_after_rd", rd, 32'h60);

        // queued write accepted, third write overruns; inverted MISO
        miso_inv = 1'b1;
        rb = rise_cnt;
        bus_write(A_TX, 32'h0000_00FF);
        wait_ss(1'b0, 20, "t2_ss_low");
        bus_write(A_TX, 32'h1111_1111);
        bus_write(A_TX, 32'h2222_2222);
        bus_read(A_ST, rd); check("t2_status_toe", rd, 32'h110);
        wait_ss(1'b1, 400, "t2_ss_high1");
        miso_inv = 1'b0;
        wait_ss(1'b0, 30, "t2_ss_low2");
        wait_ss(1'b1, 400, "t2_ss_high2");
        check("t2_rises", 32'(rise_cnt - rb), 32'd64);
        check("t2_mosi2", mosi_cap, 32'h1111_1111);
        cyc(12);
        bus_read(A_ST, rd); check("t2_status_roe", rd, 32'h1F8);
        bus_write(A_ST, 32'h0);
        bus_read(A_ST, rd); check("t2_status_clr", rd, 32'h60);
        bus_read(A_RX, rd); check("t2_rxdata_first", rd, 32'hFFFF_FF00);

        // SSO: two words with SS_n held low
        bus_write(A_CTRL, 32'h400);
        bus_read(A_CTRL, rd); check("t3_control", rd, 32'h400);
        rb = rise_cnt;
        sb = ss_rise_cnt;
        bus_write(A_TX, 32'h0F0F_0F0F);
        wait_ss(1'b0, 20, "t3_ss_low");
        bus_write(A_TX, 32'hF0F0_F0F0);
        wait_ss(1'b1, 700, "t3_ss_high");
        check("t3_ss_rises", 32'(ss_rise_cnt - sb), 32'd1);
        check("t3_rises", 32'(rise_cnt - rb), 32'd64);
        check("t3_mosi2", mosi_cap, 32'hF0F0_F0F0);
        cyc(12);
        bus_read(A_ST, rd); check("t3_status", rd, 32'h1E8);
        bus_write(A_ST, 32'h0);
        bus_read(A_RX, rd); check("t3_rxdata", rd, 32'h0F0F_0F0F);

        // SSO off: SS_n must rise for at least GAP_CYCLES between words
        bus_write(A_CTRL, 32'h0);
        bus_write(A_TX, 32'h3C3C_3C3C);
        wait_ss(1'b0, 20, "t4_ss_low");
        bus_write(A_TX, 32'hC3C3_C3C3);
        wait_ss(1'b1, 400, "t4_ss_high1");
        wait_ss(1'b0, 30, "t4_ss_low2");
        check("t4_gap_ge_80ns", 32'(gap_ns >= 80), 32'd1);
        wait_ss(1'b1, 400, "t4_ss_high2");
        cyc(12);
        check("t4_mosi2", mosi_cap, 32'hC3C3_C3C3);
        bus_read(A_RX, rd); check("t4_rxdata", rd, 32'h3C3C_3C3C);
        bus_write(A_ST, 32'h0);

        // interrupts
        bus_write(A_CTRL, 32'h80);
        check("t5_irq_idle", 32'(bus.irq), 32'd0);
        bus_write(A_TX, 32'h5A5A_5A5A);
        wait_ss(1'b0, 20, "t5_ss_low");
        wait_ss(1'b1, 400, "t5_ss_high");
        check("t5_irq_same_cycle", 32'(bus.irq), 32'd0);
        cyc(1);
        check("t5_irq_next_cycle", 32'(bus.irq), 32'd1);
        bus_read(A_RX, rd); check("t5_rxdata", rd, 32'h5A5A_5A5A);
        cyc(1);
        check("t5_irq_cleared", 32'(bus.irq), 32'd0);
        bus_write(A_CTRL, 32'h40);
        check("t5_irq_trdy", 32'(bus.irq), 32'd1);
        bus_write(A_CTRL, 32'h0);

        // reset mid-SHIFT
        bus_write(A_TX, 32'hFFFF_FFFF);
        wait_ss(1'b0, 20, "t6_ss_low");
        cyc(40);
        wait_sclk_high(20, "t6_sclk_high");
        reset_n = 1'b0;
        #1;
        check("t6_ss_n_async", 32'(ss_n), 32'd1);
        check("t6_sclk_async", 32'(sclk), 32'd0);
        check("t6_mosi_async", 32'(mosi), 32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        bus_read(A_ST, rd);   check("t6_status", rd, 32'h60);
        bus_read(A_CTRL, rd); check("t6_control", rd, 32'h0);

`ifdef SPI_MASTER_EOP_EN
        bus_write(A_EOP, 32'h55);
        bus_read(A_EOP, rd); check("t7_eop_value", rd, 32'h55);
        bus_write(A_CTRL, 32'h200);
        bus_write(A_TX, 32'h55);
        check("t7_eop_irq", 32'(bus.irq), 32'd1);
        bus_read(A_ST, rd); check("t7_eop_bit", rd & 32'h200, 32'h200);
        bus_write(A_ST, 32'h0);
        bus_read(A_ST, rd); check("t7_eop_clr", rd & 32'h200, 32'h0);
        wait_ss(1'b1, 400, "t7_ss_high");
`else
        bus_write(A_EOP, 32'h55);
        bus_read(A_EOP, rd); check("t7_addr6_zero", rd, 32'h0);
        bus_write(A_CTRL, 32'h200);
        bus_read(A_CTRL, rd); check("t7_ieop_absent", rd, 32'h0);
        bus_read(A_ST, rd); check("t7_eop_bit_zero", rd & 32'h200, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
Avalon-MM-controlled SPI master, the initiator end of the team's SPI slave links (mode 0, MSB first).
- Serialises CPU-written words onto SCLK/MOSI.
- Captures MISO into a receive holding register.
- Drives a single active-low slave select.
- Sits on the Qsys control fabric next to the SPI slave peripherals and uses the same two-cycle register-access scheme and status/control bit layout.

Parameters:
DATA_WIDTH, 32, bits per SPI transfer (2..32)
CLK_DIV, 196, system clocks per SCLK half-period (>=2); 50 MHz/196/2 ~ 128 kHz
GAP_CYCLES, 196, minimum SS_n-high clocks between words

Ports:
clk  in  1  system clock
reset_n  in  1  active-low reset
spi_select  in  1  Avalon chip select
mem_addr  in  3  register address
read_n  in  1  active-low read
write_n  in  1  active-low write
data_from_cpu  in  32  write data
data_to_cpu  out  32  registered read data
irq  out  1  registered interrupt
SCLK  out  1  serial clock
MOSI  out  1  master-out data
MISO  in  1  master-in data
SS_n  out  1  slave select, active low

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low; clk/reset_n.
- Reset values: SCLK=0, MOSI=0, SS_n=1, data_to_cpu=0, irq=0, TRDY=1, RRDY=0, TOE=ROE=0, control=0, holding regs=0, state=IDLE.
- Register map: 0 rxdata (r); 1 txdata (w); 2 status (r; any write clears ROE/TOE/RRDY); 3 control (r/w).
- Status bits: ROE[3], TOE[4], TMT[5], TRDY[6], RRDY[7], E[8]=ROE|TOE.
  - TMT = TRDY & state==IDLE.
- Control bits: IROE[3], ITOE[4], ITRDY[6], IRRDY[7], IE[8], SSO[10] (hold SS_n low between words).
- Register access: strobes qualified by ~strobe_d1 (one access per two cycles). data_to_cpu is registered 1 cycle after the address.
- Reads of rxdata clear RRDY on the second cycle.
- txdata write:
  - TRDY=1: load tx_holding, TRDY<=0.
  - TRDY=0: data dropped, TOE<=1.
- irq <= OR of (each status bit & its enable); E gated by IE. Registered, 1 cycle latency.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. A half-period tick fires every CLK_DIV clocks; the tick counter resets on each state entry.
  - IDLE: if TRDY=0, load shift_reg<=tx_holding, TRDY<=1, SS_n<=0, MOSI<=MSB -> SETUP.
  - SETUP: one half-period -> SHIFT with SCLK rising.
  - SHIFT: each rising edge samples MISO into rx bit; each falling edge shifts left and drives the next MSB. After DATA_WIDTH rising edges plus the final falling edge -> HOLD.
  - HOLD: one half-period with SCLK=0, then update receive state:
    - RRDY=0: rx_holding<=received word, RRDY<=1.
    - RRDY=1: rx_holding is kept and ROE<=1.
    - If SSO=1 and TRDY=0: go directly to SETUP (SS_n stays low, next word loaded).
    - Otherwise: SS_n<=1 -> GAP.
  - GAP: GAP_CYCLES clocks -> IDLE.
- Simultaneous events:
  - Completion and rxdata read in the same cycle: new data loaded, RRDY stays 1, no ROE.
  - Completion and status write in the same cycle: completion's RRDY/ROE sets win.
  - txdata write in the IDLE load cycle: TRDY is already 0 -> TOE.
- DATA_WIDTH<32: tx uses the low bits; rxdata is zero-extended.
- Reset mid-transfer: immediate return to reset values; SS_n=1 asynchronously.

Optional Feature:
SPI_MASTER_EOP_EN
- Defined:
  - Register 6 = end-of-packet value (r/w).
  - Status bit EOP[9] and control bit IEOP[9] exist.
  - EOP<=1 when the txdata write data equals the value, or when an rxdata read returns the value.
  - Status write clears EOP.
- Undefined:
  - Address 6 reads 0; writes are ignored.
  - Bit 9 reads 0.

Decomposition:
- Package spi_master_pkg:
  - register address localparams;
  - status/control bit indices;
  - FSM state enum;
  - function clog2 for counter widths.
- Sub-module spi_master_tick (half-period tick/counter, restart input, CLK_DIV parameter).

Test Plan:
- Write 0xA5A5_0F0F to txdata, MISO loopback from MOSI -> SS_n low, 32 SCLK rising edges at 128 kHz, MOSI MSB-first; rxdata=0xA5A5_0F0F, RRDY=1, TMT=1 after GAP.
- Two txdata writes back-to-back during a transfer -> second accepted (TRDY was 1), third write while TRDY=0 sets TOE and status reads 0x110 with E.
- Two transfers without reading rxdata -> ROE=1, rxdata holds the first word; status write 0 clears ROE/RRDY.
- SSO=1, two queued words -> SS_n stays low across both, no GAP; SSO=0 -> SS_n high for >=GAP_CYCLES between words.
- IRRDY=1, transfer completes -> irq=1 one cycle after RRDY; rxdata read -> irq=0; reset_n pulsed mid-SHIFT -> SS_n=1, SCLK=0 immediately, TRDY=1.
- With SPI_MASTER_EOP_EN: eop=0x55, IEOP=1, write txdata 0x55 -> EOP=1, irq=1; without the macro, reading addr 6 returns 0.
